// File: rtl/fft8_pkg.sv
// rtl/fft8_pkg.sv - shared FFT8 constants: operand/write-back bit map, ALU codes, controller states
package fft8_pkg;

    localparam int WBF_W      = 26;
    localparam int ALUREG_W   = 48;
    localparam int ALU_MODE_W = 8;

    localparam logic [ALU_MODE_W-1:0] ALU_NOP = 8'h00;
    localparam logic [ALU_MODE_W-1:0] ALU_ADD = 8'h01;
    localparam logic [ALU_MODE_W-1:0] ALU_SUB = 8'h02;

    // Operand selects: one 8-bit one-hot field per (operand port, source bank).
    localparam int ALUREG_A_X_0  = 0;
    localparam int ALUREG_A_S1_0 = 8;
    localparam int ALUREG_B_X_0  = 16;
    localparam int ALUREG_B_S1_0 = 24;
    localparam int ALUREG_A_S2_0 = 32;
    localparam int ALUREG_B_S2_0 = 40;

    // Write-back enables. S1_k sits at WBF_S1_0 + k.
    localparam int WBF_S1_0      = 0;
    // Butterfly destinations of stage 2, consecutive in issue order.
    localparam int WBF_S2_0      = 8;
    localparam int WBF_S2_2      = 9;
    localparam int WBF_S2_4      = 10;
    localparam int WBF_S2_6      = 11;
    // Odd stage-2 terms are plain copies of stage-1 values (real/imag split).
    localparam int WBF_S2_1_REEL = 12;
    localparam int WBF_S2_1_IMAG = 13;
    localparam int WBF_S2_3_REEL = 14;
    localparam int WBF_S2_3_IMAG = 15;
    localparam int WBF_S2_5_REEL = 16;
    localparam int WBF_S2_5_IMAG = 17;
    localparam int WBF_S2_7_REEL = 18;
    localparam int WBF_S2_7_IMAG = 19;
    // Bits 20..25 belong to the final-stage registers, written by the output sequencer.
    localparam int WBF_S3_0      = 20;

    localparam logic [WBF_W-1:0] WBF_S2_COPY_MASK = WBF_W'(8'hFF) << WBF_S2_1_REEL;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_S1       = 3'd2,
        ST_S1_DRAIN = 3'd3,
        ST_S2       = 3'd4,
        ST_S2_DRAIN = 3'd5,
        ST_DONE     = 3'd6
    } fft8_state_e;

endpackage

// File: rtl/fft8_wb_pipe.sv
// rtl/fft8_wb_pipe.sv - DEPTH-deep write-back enable delay line with synchronous flush
//
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_flush      : clears every stage on the next edge (the push of that cycle is dropped)
//   i_push       : one-hot destination mask of the current issue, 0 for a bubble
//   o_data       : mask issued DEPTH cycles earlier
module fft8_wb_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 26
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_push,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_push;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/fft8_controller.sv
// rtl/fft8_controller.sv - control sequencer for the 8-point radix-2 FFT datapath
//
// Parameter ALU_LAT (1..4): ALU result latency; write-back lands ALU_LAT+1 cycles after issue.
// Optional macro FFT8_CTRL_RESTART_EN: start_i while busy aborts and restarts the transform;
// when undefined it is ignored.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : transform request, sampled every cycle
//   busy_o          : transform in progress (includes the accept cycle)
//   start_o         : datapath start, same cycle as an accepted start_i
//   alu_reg_o       : operand-select one-hots, alu_mode_o: ALU_ADD/ALU_SUB, both 0 when idle
//   wr_enable_o     : delayed write-back masks ORed with stage-2 copy writes
//   valid_o         : one-cycle completion pulse
//   valid_states_o  : {DONE, S2_DRAIN, S2, S1_DRAIN, S1, LOAD}
module fft8_controller
    import fft8_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  start_o,
    output logic [ALUREG_W-1:0]   alu_reg_o,
    output logic [ALU_MODE_W-1:0] alu_mode_o,
    output logic [WBF_W-1:0]      wr_enable_o,
    output logic                  valid_o,
    output logic [5:0]            valid_states_o
);

    localparam int         WB_DLY     = ALU_LAT + 1;
    localparam logic [2:0] DRAIN_LAST = 3'(WB_DLY - 1);

    fft8_state_e r_state;
    logic [2:0]  r_cnt;

    logic                  w_idle;
    logic                  w_run;
    logic                  w_accept;
    logic                  w_flush;
    logic [ALUREG_W-1:0]   w_sel;
    logic [ALU_MODE_W-1:0] w_mode;
    logic [WBF_W-1:0]      w_dest;
    logic [WBF_W-1:0]      w_copy;
    logic [WBF_W-1:0]      w_pipe;

    assign w_idle = (r_state == ST_IDLE);
    // Abortable states: everything between the accept and the DONE cycle.
    assign w_run  = (r_state != ST_IDLE) && (r_state != ST_DONE);

`ifdef FFT8_CTRL_RESTART_EN
    assign w_accept = !rst && start_i && (w_idle || w_run);
    assign w_flush  = !rst && start_i && w_run;
`else
    assign w_accept = !rst && start_i && w_idle;
    assign w_flush  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_LOAD: begin
                    r_state <= ST_S1;
                    r_cnt   <= '0;
                end
                ST_S1: begin
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_S1_DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_S1_DRAIN: begin
                    if (r_cnt == DRAIN_LAST) begin
                        r_state <= ST_S2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_S2: begin
                    if (r_cnt == 3'd3) begin
                        r_state <= ST_S2_DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_S2_DRAIN: begin
                    if (r_cnt == DRAIN_LAST) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Issue words decode directly from state and counter.
    always_comb begin
        w_sel  = '0;
        w_mode = ALU_NOP;
        w_dest = '0;
        w_copy = '0;
        case (r_state)
            ST_S1: begin
                // k and k-4 share operands X_(k mod 4), X_(k mod 4 + 4); k[2] selects SUB.
                w_sel  = (ALUREG_W'(1) << (ALUREG_A_X_0 + int'(r_cnt[1:0])))
                       | (ALUREG_W'(1) << (ALUREG_B_X_0 + 4 + int'(r_cnt[1:0])));
                w_mode = r_cnt[2] ? ALU_SUB : ALU_ADD;
                w_dest = WBF_W'(1) << (WBF_S1_0 + int'(r_cnt));
            end
            ST_S2: begin
                // cnt[1] picks the pair (S1_0,S1_2) or (S1_4,S1_6); cnt[0] selects SUB.
                w_sel  = (ALUREG_W'(1) << (ALUREG_A_S1_0 + 4 * int'(r_cnt[1])))
                       | (ALUREG_W'(1) << (ALUREG_B_S1_0 + 4 * int'(r_cnt[1]) + 2));
                w_mode = r_cnt[0] ? ALU_SUB : ALU_ADD;
                w_dest = WBF_W'(1) << (WBF_S2_0 + int'(r_cnt[1:0]));
                // Copy writes need no ALU pass, so they skip the delay line.
                if (r_cnt == 3'd0) w_copy = WBF_S2_COPY_MASK;
            end
            default: ;
        endcase
    end

    fft8_wb_pipe #(
        .DEPTH (WB_DLY),
        .WIDTH (WBF_W)
    ) u_wb_pipe (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (w_flush),
        .i_push  (w_dest),
        .o_data  (w_pipe)
    );

    assign start_o        = w_accept;
    assign busy_o         = !w_idle || w_accept;
    assign alu_reg_o      = w_sel;
    assign alu_mode_o     = w_mode;
    assign wr_enable_o    = w_pipe | w_copy;
    assign valid_o        = (r_state == ST_DONE);
    assign valid_states_o = {r_state == ST_DONE, r_state == ST_S2_DRAIN, r_state == ST_S2,
                             r_state == ST_S1_DRAIN, r_state == ST_S1, r_state == ST_LOAD};

endmodule

// File: tb/tb_fft8_controller.sv
// tb/tb_fft8_controller.sv - scoreboard bench for fft8_controller at ALU_LAT 1 and 3
`timescale 1ns/1ps
module tb_fft8_controller;
    import fft8_pkg::*;

    localparam int NDUT    = 2;
    localparam int K_START = 0;
    localparam int K_ISSUE = 1;
    localparam int K_WR    = 2;
    localparam int K_VALID = 3;

    typedef struct {
        int          kind;
        int          dut;
        int          cyc;
        logic [47:0] sel;
        logic [7:0]  mode;
        logic [25:0] mask;
    } ev_t;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        start_i = 1'b0;
    logic        busy   [NDUT];
    logic        starto [NDUT];
    logic [47:0] sel    [NDUT];
    logic [7:0]  mode   [NDUT];
    logic [25:0] wr     [NDUT];
    logic        valid  [NDUT];
    logic [5:0]  vstate [NDUT];

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    ev_t q[$];
    int  t_run [NDUT];
    int  t_old [NDUT];

    fft8_controller #(.ALU_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy[0]), .start_o(starto[0]),
        .alu_reg_o(sel[0]), .alu_mode_o(mode[0]), .wr_enable_o(wr[0]), .valid_o(valid[0]),
        .valid_states_o(vstate[0])
    );

    fft8_controller #(.ALU_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy[1]), .start_o(starto[1]),
        .alu_reg_o(sel[1]), .alu_mode_o(mode[1]), .wr_enable_o(wr[1]), .valid_o(valid[1]),
        .valid_states_o(vstate[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wbd(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int lat_of(input int d);
        return 14 + 2 * wbd(d);
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_START: return "start_o";
            K_ISSUE: return "issue";
            K_WR:    return "wr_enable";
            default: return "valid_o";
        endcase
    endfunction

    // Expected one-hot state for a cycle offset ph after the accept cycle.
    function automatic logic [5:0] vs_of(input int ph, input int w);
        if (ph == 1)                      return 6'b000001;
        if (ph >= 2 && ph <= 9)           return 6'b000010;
        if (ph >= 10 && ph <= 9 + w)      return 6'b000100;
        if (ph >= 10 + w && ph <= 13 + w) return 6'b001000;
        if (ph >= 14 + w && ph <= 13 + 2*w) return 6'b010000;
        if (ph == 14 + 2*w)               return 6'b100000;
        return 6'b000000;
    endfunction

    function automatic void push(input int kind, input int d, input int c,
                                 input logic [47:0] s, input logic [7:0] m, input logic [25:0] k);
        ev_t e;
        e.kind = kind; e.dut = d; e.cyc = c; e.sel = s; e.mode = m; e.mask = k;
        q.push_back(e);
    endfunction

    // Full expected schedule of one transform accepted in cycle c.
    function automatic void model_accept(input int d, input int c);
        int          w = wbd(d);
        int          s2a [4] = '{0, 0, 4, 4};
        int          s2b [4] = '{2, 2, 6, 6};
        int          s2d [4] = '{WBF_S2_0, WBF_S2_2, WBF_S2_4, WBF_S2_6};
        logic [47:0] s;
        logic [25:0] cp;
        int          base = c + 10 + w;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].dut == d && q[i].cyc > c) q.delete(i);
        push(K_START, d, c, '0, '0, '0);
        for (int k = 0; k < 8; k++) begin
            s = '0;
            s[ALUREG_A_X_0 + (k % 4)]     = 1'b1;
            s[ALUREG_B_X_0 + (k % 4) + 4] = 1'b1;
            push(K_ISSUE, d, c + 2 + k, s, (k < 4) ? ALU_ADD : ALU_SUB, '0);
        end
        for (int j = 0; j < 4; j++) begin
            s = '0;
            s[ALUREG_A_S1_0 + s2a[j]] = 1'b1;
            s[ALUREG_B_S1_0 + s2b[j]] = 1'b1;
            push(K_ISSUE, d, base + j, s, (j % 2 == 1) ? ALU_SUB : ALU_ADD, '0);
        end
        for (int k = 0; k < 8; k++) begin
            cp = '0;
            cp[WBF_S1_0 + k] = 1'b1;
            push(K_WR, d, c + 2 + k + w, '0, '0, cp);
        end
        cp = '0;
        cp[WBF_S2_1_REEL] = 1'b1; cp[WBF_S2_1_IMAG] = 1'b1;
        cp[WBF_S2_3_REEL] = 1'b1; cp[WBF_S2_3_IMAG] = 1'b1;
        cp[WBF_S2_5_REEL] = 1'b1; cp[WBF_S2_5_IMAG] = 1'b1;
        cp[WBF_S2_7_REEL] = 1'b1; cp[WBF_S2_7_IMAG] = 1'b1;
        push(K_WR, d, base, '0, '0, cp);
        for (int j = 0; j < 4; j++) begin
            cp = '0;
            cp[s2d[j]] = 1'b1;
            push(K_WR, d, base + j + w, '0, '0, cp);
        end
        push(K_VALID, d, c + lat_of(d), '0, '0, '0);
    endfunction

    function automatic void check_kind(input int kind, input int d, input logic present,
                                       input logic [47:0] s, input logic [7:0] m, input logic [25:0] k);
        int  idx = -1;
        ev_t e;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].kind == kind && q[i].dut == d) begin
                idx = i;
                break;
            end
        end
        if (present) begin
            checks++;
            if (idx < 0) begin
                errors++;
                $display("FAIL %s dut%0d cycle %0d: unexpected output sel=%h mode=%h mask=%h, none required",
                         kname(kind), d, cyc, s, m, k);
            end else begin
                e = q[idx];
                q.delete(idx);
                if (e.cyc != cyc || e.sel != s || e.mode != m || e.mask != k) begin
                    errors++;
                    $display("FAIL %s dut%0d: got cycle %0d sel=%h mode=%h mask=%h, required cycle %0d sel=%h mode=%h mask=%h",
                             kname(kind), d, cyc, s, m, k, e.cyc, e.sel, e.mode, e.mask);
                end
            end
        end else if (idx >= 0 && q[idx].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL %s dut%0d: nothing at cycle %0d, required at cycle %0d sel=%h mode=%h mask=%h",
                     kname(kind), d, cyc, q[idx].cyc, q[idx].sel, q[idx].mode, q[idx].mask);
            q.delete(idx);
        end
    endfunction

    // Monitor: busy/state every cycle, events through the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            int         ph;
            logic       eb;
            logic [5:0] ev;
            ph = cyc - t_run[d];
            eb = (t_run[d] >= 0) && (ph >= 0) && (ph <= lat_of(d));
            if (t_run[d] < 0)    ev = 6'b0;
            else if (ph == 0)    ev = (t_old[d] >= 0) ? vs_of(cyc - t_old[d], wbd(d)) : 6'b0;
            else                 ev = vs_of(ph, wbd(d));
            checks++;
            if (busy[d] !== eb) begin
                errors++;
                $display("FAIL busy_o dut%0d cycle %0d: got %b required %b", d, cyc, busy[d], eb);
            end
            checks++;
            if (vstate[d] !== ev) begin
                errors++;
                $display("FAIL valid_states_o dut%0d cycle %0d: got %b required %b", d, cyc, vstate[d], ev);
            end
            check_kind(K_START, d, starto[d], '0, '0, '0);
            check_kind(K_ISSUE, d, (sel[d] != '0) || (mode[d] != '0), sel[d], mode[d], '0);
            check_kind(K_WR,    d, wr[d] != '0, '0, '0, wr[d]);
            check_kind(K_VALID, d, valid[d], '0, '0, '0);
        end
    end

    task automatic step(input bit st);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        start_i = st;
        if (st) begin
            for (int d = 0; d < NDUT; d++) begin
                int ph   = cyc - t_run[d];
                bit idle = (t_run[d] < 0) || (ph > lat_of(d));
                bit abrt = 1'b0;
`ifdef FFT8_CTRL_RESTART_EN
                abrt = !idle && (ph >= 1) && (ph <= lat_of(d) - 1);
`endif
                if (idle || abrt) begin
                    t_old[d] = t_run[d];
                    t_run[d] = cyc;
                    model_accept(d, cyc);
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst     = 1'b1;
            start_i = 1'b0;
            q.delete();
            for (int d = 0; d < NDUT; d++) begin
                t_run[d] = -1;
                t_old[d] = -1;
            end
        end
        step(1'b0);
    endtask

    task automatic idle_for(input int n);
        repeat (n) step(1'b0);
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            t_run[d] = -1;
            t_old[d] = -1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0);
        step(1'b1);          // accepted at cycle 5
        idle_for(30);
        // second request seven cycles into a run
        step(1'b1);
        idle_for(6);
        step(1'b1);
        idle_for(40);
        // requests in the DONE cycle and the first IDLE cycle of the ALU_LAT=1 unit
        step(1'b1);
        idle_for(17);
        step(1'b1);
        step(1'b1);
        idle_for(40);
        // reset in the middle of stage-1 write-backs
        step(1'b1);
        idle_for(9);
        do_reset(2);
        idle_for(30);
        // randomised requests with occasional resets
        for (int i = 0; i < 2000; i++) begin
            int r = $urandom_range(0, 255);
            if (r == 0) do_reset(2);
            else        step(r < 12);
        end
        idle_for(40);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events never seen, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
